// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : UART serial receiver. Double-synchronises rxd, detects the
//                start-bit falling edge, re-times a down-counter to that edge
//                and samples every bit at its centre. Emits one byte per
//                frame with single-cycle valid / frame_err / parity_err strobes.
//  Options     : define UART_RX_PARITY_EN for an even-parity bit between the
//                data and stop bits; otherwise parity_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115200
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  // Bit period and half period in system clocks; counter reload values.
  localparam int unsigned c_P        = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned c_HALF     = c_P >> 1;
  localparam logic [31:0] c_BIT_LOAD  = 32'(c_P - 1);
  localparam logic [31:0] c_HALF_LOAD = 32'(c_HALF - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_ferr, w_ferr_nxt;
  logic        r_rxd_m, r_rxd_s, r_rxd_p;
`ifdef UART_RX_PARITY_EN
  logic        r_pmis, w_pmis_nxt;
  logic        r_perr, w_perr_nxt;
`endif

  // Two-flop synchroniser plus one delayed copy for start-edge detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_m <= 1'b1;
      r_rxd_s <= 1'b1;
      r_rxd_p <= 1'b1;
    end else begin
      r_rxd_m <= rxd;
      r_rxd_s <= r_rxd_m;
      r_rxd_p <= r_rxd_s;
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output strobe registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pmis  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_pmis  <= w_pmis_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  // Next-state and datapath logic; all sampling happens when the counter hits 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == 32'd0) ? r_cnt : r_cnt - 32'd1;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pmis_nxt  = r_pmis;
    w_perr_nxt  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Only a high-to-low transition starts a frame, so a held break
        // line never retriggers until it has returned high.
        w_cnt_nxt = r_cnt;
        if (r_rxd_p && !r_rxd_s) begin
          w_cnt_nxt   = c_HALF_LOAD;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == 32'd0) begin
          if (r_rxd_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = c_BIT_LOAD;
            w_idx_nxt   = 3'd0;
            w_state_nxt = S_DATA;
`ifdef UART_RX_PARITY_EN
            w_pmis_nxt  = 1'b0;
`endif
          end
        end
      end
      S_DATA: begin
        if (r_cnt == 32'd0) begin
          w_shift_nxt = {r_rxd_s, r_shift[7:1]};
          w_cnt_nxt   = c_BIT_LOAD;
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        // Even parity: the parity bit must equal the XOR of the data bits.
        if (r_cnt == 32'd0) begin
          w_pmis_nxt  = r_rxd_s ^ (^r_shift);
          w_cnt_nxt   = c_BIT_LOAD;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == 32'd0) begin
          w_state_nxt = S_IDLE;
          if (r_rxd_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt  = r_pmis;
`endif
          end else begin
            w_ferr_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx at default parameters. Frames
//                are driven bit by bit; each expected strobe (kind, data,
//                parity flag, arrival window) is queued by the driver and
//                checked by an independent monitor when the DUT strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int P    = 868;
  localparam int HALF = 434;
`ifdef UART_RX_PARITY_EN
  localparam int LAT  = 3 + HALF + 10 * P;
`else
  localparam int LAT  = 3 + HALF + 9 * P;
`endif

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rxd     = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  typedef struct {
    bit         is_ferr;
    logic [7:0] d;
    bit         perr;
    int         tmin;
    int         tmax;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (P) @(negedge sys_clk);
  endtask

  // Queue the expected outcome, then drive the whole frame.
  task automatic send(input logic [7:0] d, input logic par, input logic stop);
    exp_t e;
    e.tmin = cyc + LAT - 1;
    e.tmax = cyc + LAT;
    if (stop) begin
      e.is_ferr = 1'b0;
      e.d       = d;
`ifdef UART_RX_PARITY_EN
      e.perr    = (par != ^d);
`else
      e.perr    = 1'b0;
`endif
      last_good = d;
    end else begin
      e.is_ferr = 1'b1;
      e.d       = last_good;
      e.perr    = 1'b0;
    end
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) begin end
`endif
    drive_bit(stop);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge sys_clk) begin
    if (rst_n === 1'b1) begin
      if (valid || frame_err) begin
        chk("valid_ferr_exclusive", {31'd0, valid & frame_err}, 32'd0);
        if (q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, valid, frame_err}, 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("strobe_frame_err", {31'd0, frame_err}, {31'd0, mon_e.is_ferr});
          chk("strobe_valid", {31'd0, valid}, {31'd0, !mon_e.is_ferr});
          chk("strobe_data", {24'd0, data}, {24'd0, mon_e.d});
          chk("strobe_parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
          n_cmp++;
          if (cyc < mon_e.tmin || cyc > mon_e.tmax) begin
            n_bad++;
            $display("FAIL strobe_timing: actual cycle=%0d required %0d..%0d",
                     cyc, mon_e.tmin, mon_e.tmax);
          end
        end
      end else if (parity_err) begin
        chk("parity_err_without_valid", {31'd0, parity_err}, 32'd0);
      end
    end
  end

  initial begin
    int busy_cnt;
    // Reset values.
    idle(3);
    chk("reset_data", {24'd0, data}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_parity_err", {31'd0, parity_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Plain frame 0x55 (even parity bit 0).
    send(8'h55, 1'b0, 1'b1);
    idle(50);

    // 100-cycle glitch: false start, busy for HALF cycles, data unchanged.
    busy_cnt = 0;
    rxd = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 100) rxd = 1'b1;
      @(negedge sys_clk);
      busy_cnt += int'(busy);
    end
    chk("glitch_busy_cycles", busy_cnt, HALF);
    chk("glitch_busy_after", {31'd0, busy}, 32'd0);
    chk("glitch_data_kept", {24'd0, data}, 32'h55);
    idle(50);

    // Frame 0xA3 with stop bit low: frame error, data stays 0x55.
    send(8'hA3, 1'b0, 1'b0);
    rxd = 1'b1;
    idle(2 * P);
    chk("ferr_data_kept", {24'd0, data}, 32'h55);

    // Back-to-back 0x00 then 0xFF.
    send(8'h00, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    idle(50);
    chk("b2b_last_data", {24'd0, data}, 32'hFF);

    // Reset in the middle of frame 0x3C (after data bit 3).
    rxd = 1'b0;
    repeat (P) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) drive_bit(i >= 2);
    rst_n = 1'b0;
    rxd   = 1'b1;
    last_good = 8'h00;
    idle(2);
    chk("midreset_data", {24'd0, data}, 32'h00);
    chk("midreset_valid", {31'd0, valid}, 32'd0);
    chk("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("midreset_parity_err", {31'd0, parity_err}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(100);
    chk("postreset_idle_busy", {31'd0, busy}, 32'd0);
    send(8'h3C, 1'b0, 1'b1);
    idle(50);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so the correct even-parity bit is 1.
    send(8'h07, 1'b0, 1'b1);
    idle(50);
    send(8'h07, 1'b1, 1'b1);
    idle(50);
`endif

    idle(P);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
